sync_fifo_prog: RTL
===================

# sync_fifo_prog

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock. It adds:

- selectable standard or first-word-fall-through read mode;
- programmable almost-full and almost-empty thresholds;
- a live fill-level count;
- sticky overflow and underflow error flags.

It sits between a streaming producer and consumer inside one clock domain and needs no pointer synchronisers.

## Interface

- a_width, 6, address width; depth = 2^a_width words
- d_width, 16, data word width
- fwft, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

- Clk  in  1  single clock, rising edge
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  write request
- wr_data  in  d_width  write word
- rd_en  in  1  read request (pop in fwft mode)
- rd_data  out  d_width  read word
- rd_valid  out  1  rd_data holds a valid word
- af_thresh  in  a_width+1  almost-full threshold, quasi-static
- ae_thresh  in  a_width+1  almost-empty threshold, quasi-static
- clr_err  in  1  clears overflow/underflow
- fill_level  out  a_width+1  words stored, 0..2^a_width
- fifo_full  out  1  fill_level == 2^a_width
- fifo_empty  out  1  fill_level == 0
- almost_full  out  1  fill_level >= af_thresh
- almost_empty  out  1  fill_level <= ae_thresh
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation

- Pointers are a_width+1 bits and wrap modulo 2^(a_width+1).
- fill_level = wr_ptr − rd_ptr, computed modulo 2^(a_width+1).
- Write is accepted iff wr_en && !fifo_full, using the flag value before the edge. An accepted write stores wr_data at wr_ptr[a_width-1:0] and increments wr_ptr.
- Read is accepted iff rd_en && !fifo_empty. An accepted read increments rd_ptr.
- An accepted read and an accepted write in the same cycle are both performed; fill_level is unchanged.
- A write to a full FIFO is dropped even if a read occurs in the same cycle. The producer sees the full flag and retries.
- Standard mode (fwft=0):
  - rd_data is registered, loaded from mem[rd_ptr] on an accepted read.
  - rd_valid pulses high for exactly the cycle after each accepted read.
  - Otherwise rd_data holds its last value.
- FWFT mode (fwft=1):
  - rd_data = mem[rd_ptr] whenever !fifo_empty.
  - rd_valid = !fifo_empty.
  - rd_en pops the current head word.
- All flags and fill_level are decoded from the registered pointers. There is no combinational path from wr_en or rd_en to any output.
- Error flags:
  - overflow is set on wr_en && fifo_full; underflow is set on rd_en && fifo_empty.
  - clr_err clears both flags.
  - When set and clear occur in the same cycle, set wins.
- Thresholds are unchecked. af_thresh=0 gives almost_full constantly 1. ae_thresh ≥ 2^a_width gives almost_empty constantly 1.
- Reset values:
  - pointers, fill_level, rd_data, rd_valid, overflow, underflow: 0
  - fifo_empty: 1; fifo_full: 0
  - almost_* follow their threshold rules at level 0
- Reset asserted mid-operation discards all contents immediately. Memory contents are not cleared.

## Timing

- Write to read-visibility, standard mode:
  - fifo_empty deasserts 1 cycle after the accepted write edge.
  - rd_data/rd_valid appear 1 cycle after the accepted read edge.
- Write to read-visibility, FWFT mode: the head word and rd_valid appear 1 cycle after the write edge into an empty FIFO.
- Flag updates: fill_level, fifo_full, fifo_empty, almost_full and almost_empty update in the cycle following the causing edge.
- Throughput: sustained 1 write + 1 read per cycle at any fill level except full (writes blocked) and empty (reads blocked).

## Structure

- Package sync_fifo_pkg holds:
  - mode constants FIFO_STD=0 and FIFO_FWFT=1;
  - a function computing level width from a_width.
- Sub-module fifo_mem is a simple dual-port register array with 1 write port and 1 read port, d_width × 2^a_width.
  - Asynchronous read port, so FWFT can use it directly.
  - The standard-mode output register lives in sync_fifo_prog.
- Pointer, flag and error logic stay in the top module.

## Test plan

Bench configuration: a_width=6, d_width=16.

- **Fill to full, standard mode:**
  - Stimulus: reset, then write 1..64 with rd_en=0.
  - Expected: fifo_full=1 and fill_level=64 after the 64th write. A 65th write (value 999) sets overflow and is not stored.
- **Drain, standard mode:**
  - Stimulus: from full, rd_en=1 for 64 cycles.
  - Expected: rd_data sequence 1..64, each with rd_valid the cycle after its read. Then fifo_empty=1. A further rd_en sets underflow.
- **FWFT mode:**
  - Stimulus: fwft=1; write 420 into the empty FIFO.
  - Expected: next cycle rd_data=420 and rd_valid=1 with no rd_en. Popping returns fifo_empty=1 one cycle later.
- **Concurrent read/write at level 32:**
  - Stimulus: 100 cycles of wr_en=rd_en=1.
  - Expected: fill_level stays 32. Data order is preserved across pointer wrap.
- **Thresholds:**
  - Stimulus: af_thresh=48, ae_thresh=8; fill from 0 to 64.
  - Expected: almost_empty deasserts at level 9; almost_full asserts at level 48.
- **Error flags and reset:**
  - Stimulus 1: assert clr_err in the same cycle as an overflowing write. Expected: overflow stays 1. clr_err alone then clears it.
  - Stimulus 2: assert resetn=0 mid-stream at level 20. Expected: immediately fill_level=0, fifo_empty=1, rd_valid=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Level/pointer width: one extra bit so full and empty are distinguishable.
  function automatic int level_width(input int a_width);
    return a_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of sync_fifo_prog: write port, read port, thresholds and status.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int a_width = 6,
  parameter int d_width = 16
);

  localparam int l_width = level_width(a_width);

  // Handshake: a write is taken on a rising edge when wr_en=1 and fifo_full=0
  // (flag value before the edge); a read/pop is taken when rd_en=1 and fifo_empty=0.
  // Requests against full/empty are dropped and flagged; the requester retries.
  logic               wr_en;
  logic [d_width-1:0] wr_data;
  logic               rd_en;
  logic [d_width-1:0] rd_data;
  logic               rd_valid;
  logic [l_width-1:0] af_thresh;
  logic [l_width-1:0] ae_thresh;
  logic               clr_err;
  logic [l_width-1:0] fill_level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               almost_full;
  logic               almost_empty;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
    input  rd_data, rd_valid, fill_level, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
    output rd_data, rd_valid, fill_level, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int a_width = 6,
  parameter int d_width = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [a_width-1:0] waddr,
  input  logic [d_width-1:0] wdata,
  input  logic [a_width-1:0] raddr,
  output logic [d_width-1:0] rdata
);

  // Storage is deliberately not reset; the pointers define what is valid.
  logic [d_width-1:0] mem [2**a_width];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard/FWFT read mode, programmable almost flags,
// live fill level and sticky overflow/underflow flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int a_width = 6,
  parameter int d_width = 16,
  parameter int fwft    = FIFO_STD
) (
  input  logic            Clk,
  input  logic            resetn,
  sync_fifo_prog_if.slave bus
);

  localparam int l_width = level_width(a_width);
  localparam logic [l_width-1:0] depth = {1'b1, {a_width{1'b0}}};

  logic [l_width-1:0] wr_ptr;
  logic [l_width-1:0] rd_ptr;
  logic [l_width-1:0] level;
  logic               full;
  logic               empty;
  logic               wr_acc;
  logic               rd_acc;
  logic [d_width-1:0] mem_rdata;
  logic               overflow_q;
  logic               underflow_q;

  // Everything visible is decoded from registered pointers only.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == depth);
  assign empty  = (level == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes precedence.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.rd_en && empty) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .a_width (a_width),
    .d_width (d_width)
  ) u_mem (
    .clk   (Clk),
    .we    (wr_acc),
    .waddr (wr_ptr[a_width-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[a_width-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (fwft == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; zero while empty so stale data never leaks out.
      assign bus.rd_data  = empty ? '0 : mem_rdata;
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [d_width-1:0] rd_data_q;
      logic               rd_valid_q;

      always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= mem_rdata;
          end
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.fill_level   = level;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (level >= bus.af_thresh);
  assign bus.almost_empty = (level <= bus.ae_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
